// File: rtl/sprite_pkg.sv
// sprite_pkg: shared widths, colour constants and register map for the sprite pipeline.
package sprite_pkg;
  localparam int SPRITE_ADDR_W = 12;
  localparam int SPRITE_COLOR_W = 4;
  localparam logic [SPRITE_COLOR_W-1:0] TRANSPARENT_COLOR = 4'd0;
  localparam logic [11:0] REG_SPRITE_X = 12'h000;
  localparam logic [11:0] REG_SPRITE_Y = 12'h001;
  localparam logic [11:0] REG_SPRITE_SHAPE = 12'h002;
  localparam logic [11:0] REG_COLLISION_BASE = 12'h100;

  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sprite_priority_encoder.sv
// sprite_priority_encoder: lowest-index-wins select plus any/multiple-active flags.
import sprite_pkg::*;

module sprite_priority_encoder #(
  parameter int NUM_SPRITES = 8
) (
  input  logic [NUM_SPRITES-1:0]             active,
  output logic [idx_w(NUM_SPRITES)-1:0]      winner,
  output logic                               any_active,
  output logic                               multi_active
);
  localparam int IDX_W = idx_w(NUM_SPRITES);

  always_comb begin
    winner = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--)
      if (active[i]) winner = IDX_W'(i);
  end

  assign any_active = |active;
  // clearing the lowest set bit leaves something only if two or more were set
  assign multi_active = |(active & (active - NUM_SPRITES'(1)));
endmodule

// File: rtl/sprite_arbiter.sv
// sprite_arbiter: shares one shape-memory port among sprites, returns the winner's pixel
// two cycles later and keeps sticky collision flags readable over the register bus.
import sprite_pkg::*;

module sprite_arbiter #(
  parameter int          NUM_SPRITES = 8,
  parameter logic [11:0] BASE_INDEX  = REG_COLLISION_BASE
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_SPRITES-1:0]               sprite_active_i,
  input  logic [NUM_SPRITES*SPRITE_ADDR_W-1:0] sprite_address_i,
  output logic [SPRITE_ADDR_W-1:0]             mem_address_o,
  input  logic [SPRITE_COLOR_W-1:0]            mem_data_i,
  output logic                                 pixel_valid_o,
  output logic [SPRITE_COLOR_W-1:0]            pixel_color_o,
  input  logic                                 register_write_i,
  input  logic                                 register_read_i,
  input  logic [11:0]                          register_index_i,
  input  logic [15:0]                          register_write_value_i,
  output logic [15:0]                          register_read_value_o
);
  localparam int IDX_W = idx_w(NUM_SPRITES);

  logic [SPRITE_ADDR_W-1:0] addr [NUM_SPRITES];
  logic [IDX_W-1:0]         winner;
  logic                     any_active, multi_active, s1_valid, hit, opaque;
  logic [NUM_SPRITES-1:0]   collision, set_mask, clr_mask;

  for (genvar g = 0; g < NUM_SPRITES; g++)
    assign addr[g] = sprite_address_i[g*SPRITE_ADDR_W +: SPRITE_ADDR_W];

  sprite_priority_encoder #(.NUM_SPRITES(NUM_SPRITES)) u_enc (
    .active       (sprite_active_i),
    .winner       (winner),
    .any_active   (any_active),
    .multi_active (multi_active)
  );

  assign hit = register_index_i == BASE_INDEX;
  assign opaque = s1_valid && mem_data_i != TRANSPARENT_COLOR;
  assign set_mask = multi_active ? sprite_active_i : '0;
  // read-to-clear and write-1-to-clear combine; new overlaps are ORed in afterwards so set wins
  assign clr_mask = {NUM_SPRITES{register_read_i && hit}}
                  | (register_write_i && hit ? register_write_value_i[NUM_SPRITES-1:0] : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_address_o <= '0;
      s1_valid <= 1'b0;
      pixel_valid_o <= 1'b0;
      pixel_color_o <= '0;
      collision <= '0;
      register_read_value_o <= '0;
    end else begin
      mem_address_o <= any_active ? addr[winner] : '0;
      s1_valid <= any_active;
      pixel_valid_o <= opaque;
      pixel_color_o <= opaque ? mem_data_i : TRANSPARENT_COLOR;
      collision <= (collision & ~clr_mask) | set_mask;
      if (register_read_i) register_read_value_o <= hit ? 16'(collision) : 16'h0000;
    end
  end
endmodule
